conv_layer_scheduler: RTL

Time-multiplexing sequencer that runs one shared `conv1d` engine over all layers of the dilated causal network for each input sample. It sits between the sample source and the datapath: it pulses the left shift buffer, selects each layer's weights and activation-cache inputs in turn, starts the engine, and clocks each layer's activation cache. It then emits the final layer output strobe. Two fault conditions are flagged: engine timeout and sample overrun.

---
 rtl/conv_layer_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//   Runs one shared conv1d engine over every layer of a dilated causal
//   network for each input sample: pulses the left shift buffer, steps the
//   layer select through all layers, starts the engine, clocks each layer's
//   activation cache and finally strobes the network output. It flags engine
//   timeouts and samples dropped while busy.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   in_v         new input sample present (accepted only while in_rdy=1)
//   in_rdy       scheduler idle
//   conv_out_v   shared engine result valid (level)
//   clr_err      clears the sticky timeout/overrun flags (a set wins)
//   lsb_en       one-cycle capture pulse to the left shift buffer
//   layer_sel    layer currently mapped onto the engine
//   relu_en      high for every layer except the last
//   conv_rst     one-cycle engine reset/start pulse
//   cache_en     one-hot one-cycle pulse, bit k clocks layer k's cache
//   out_v        one-cycle network output strobe
//   timeout      sticky engine-timeout flag
//   overrun      sticky dropped-sample flag
//   last_lat     cycles of the last completed inference, SHIFT..EMIT inclusive
module conv_layer_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 255,
    parameter int LW         = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic                  conv_out_v,
    input  logic                  clr_err,
    output logic                  lsb_en,
    output logic [LW-1:0]         layer_sel,
    output logic                  relu_en,
    output logic                  conv_rst,
    output logic [NUM_LAYERS-2:0] cache_en,
    output logic                  out_v,
    output logic                  timeout,
    output logic                  overrun,
    output logic [15:0]           last_lat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT,
        S_CACHE,
        S_EMIT
    } state_t;

    localparam logic [LW-1:0] K_LAST = LW'(NUM_LAYERS - 1);
    localparam logic [15:0]   T_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [LW-1:0] r_k;
    logic [15:0] r_t;
    logic        r_guard;
    logic [15:0] r_lat_cnt;
    logic [15:0] r_last_lat;
    logic        r_timeout;
    logic        r_overrun;
    logic        w_done;
    logic        w_abort;

    // r_guard marks the first WAIT cycle, where the engine's stale valid is ignored.
    assign w_done  = (r_state == S_WAIT) && !r_guard && conv_out_v;
    assign w_abort = (r_state == S_WAIT) && !r_guard && !conv_out_v && (r_t == T_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_v) w_next = S_SHIFT;
            S_SHIFT: w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done)       w_next = (r_k == K_LAST) ? S_EMIT : S_CACHE;
                else if (w_abort) w_next = S_IDLE;
            end
            S_CACHE: w_next = S_START;
            S_EMIT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Layer counter, WAIT counter, latency counter and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k        <= '0;
            r_t        <= '0;
            r_guard    <= 1'b0;
            r_lat_cnt  <= '0;
            r_last_lat <= '0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_next == S_IDLE)      r_k <= '0;
            else if (r_state == S_CACHE) r_k <= r_k + LW'(1);

            if (r_state == S_START) begin
                r_t     <= '0;
                r_guard <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_guard <= 1'b0;
                if (!r_guard && !conv_out_v) r_t <= r_t + 16'd1;
            end

            // Preloaded to 1 while idle so the SHIFT cycle already counts itself.
            if (r_state == S_IDLE)       r_lat_cnt <= 16'd1;
            else if (r_lat_cnt != '1)    r_lat_cnt <= r_lat_cnt + 16'd1;

            if (r_state == S_EMIT) r_last_lat <= r_lat_cnt;

            r_timeout <= w_abort | (r_timeout & ~clr_err);
            r_overrun <= (in_v && (r_state != S_IDLE)) | (r_overrun & ~clr_err);
        end
    end

    // Output decode (state register only)
    always_comb begin
        in_rdy    = (r_state == S_IDLE);
        lsb_en    = (r_state == S_SHIFT);
        conv_rst  = (r_state == S_START);
        out_v     = (r_state == S_EMIT);
        layer_sel = r_k;
        relu_en   = (r_k != K_LAST);
        cache_en  = '0;
        for (int unsigned i = 0; i < NUM_LAYERS - 1; i++) begin
            cache_en[i] = (r_state == S_CACHE) && (r_k == LW'(i));
        end
    end

    assign timeout  = r_timeout;
    assign overrun  = r_overrun;
    assign last_lat = r_last_lat;

endmodule
